// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes, registered flags
// and an accumulator that can stand in for the x operand.
module hack_alu_pipe #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [5:0]       in_ctl,
   input  logic             in_acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_o,
   output logic             out_zr,
   output logic             out_ng,
   output logic             out_cy,
   output logic             out_ov,
   output logic [WIDTH-1:0] acc_q
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; valid and its payload stay put until that edge.

   logic             s1_valid;
   logic [WIDTH-1:0] s1_xb;
   logic [WIDTH-1:0] s1_yb;
   logic             s1_f;
   logic             s1_no;
   logic             s2_valid;

   logic             s2_load;
   logic             s1_load_ok;
   logic             in_hs;
   logic             out_hs;

   logic [WIDTH-1:0] x_src;
   logic [WIDTH-1:0] xa;
   logic [WIDTH-1:0] ya;
   logic [WIDTH-1:0] xb_n;
   logic [WIDTH-1:0] yb_n;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] o_n;
   logic             cy_n;
   logic             ov_n;

   assign s2_load    = s1_valid && (!s2_valid || out_ready);
   assign s1_load_ok = !s1_valid || s2_load;
   // An ACC-sourced op must wait until every older result has reached ACC.
   assign in_ready   = !rst && s1_load_ok && !(in_acc_sel && (s1_valid || s2_valid));
   assign in_hs      = in_valid && in_ready;
   assign out_valid  = s2_valid;
   assign out_hs     = s2_valid && out_ready;

   always_comb begin
      x_src = in_acc_sel ? acc_q : in_x;
      xa    = in_ctl[5] ? '0 : x_src;
      xb_n  = in_ctl[4] ? ~xa : xa;
      ya    = in_ctl[3] ? '0 : in_y;
      yb_n  = in_ctl[2] ? ~ya : ya;
   end

   always_comb begin
      sum_ext = {1'b0, s1_xb} + {1'b0, s1_yb};
      r       = s1_f ? sum_ext[WIDTH-1:0] : (s1_xb & s1_yb);
      o_n     = s1_no ? ~r : r;
      cy_n    = s1_f && sum_ext[WIDTH];
      ov_n    = s1_f && (s1_xb[WIDTH-1] == s1_yb[WIDTH-1])
                     && (sum_ext[WIDTH-1] != s1_xb[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_xb    <= '0;
         s1_yb    <= '0;
         s1_f     <= 1'b0;
         s1_no    <= 1'b0;
      end else if (in_hs) begin
         s1_valid <= 1'b1;
         s1_xb    <= xb_n;
         s1_yb    <= yb_n;
         s1_f     <= in_ctl[1];
         s1_no    <= in_ctl[0];
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Result and flags only change on a load, so they hold during a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_o    <= '0;
         out_zr   <= 1'b0;
         out_ng   <= 1'b0;
         out_cy   <= 1'b0;
         out_ov   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         out_o    <= o_n;
         out_zr   <= (o_n == '0);
         out_ng   <= o_n[WIDTH-1];
         out_cy   <= cy_n;
         out_ov   <= ov_n;
      end else if (out_hs) begin
         s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= ACC_INIT;
      end else if (out_hs) begin
         acc_q <= out_o;
      end else if (acc_clr && !s1_valid && !s2_valid) begin
         acc_q <= ACC_INIT;
      end
   end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed self-checking bench for hack_alu_pipe: hand-computed results and
// flags flow through an expected queue checked by an output monitor.
module tb_hack_alu_pipe;

   localparam int W  = 16;
   localparam int EW = W + 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic [5:0]   in_ctl;
   logic         in_acc_sel;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_o;
   logic         out_zr;
   logic         out_ng;
   logic         out_cy;
   logic         out_ov;
   logic [W-1:0] acc_q;

   int n_checks = 0;
   int n_errors = 0;

   // Expected entries are packed as {o, zr, ng, cy, ov}.
   logic [EW-1:0] exp_q[$];

   hack_alu_pipe #(.WIDTH(W), .ACC_INIT('0)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_ctl     (in_ctl),
      .in_acc_sel (in_acc_sel),
      .acc_clr    (acc_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_o      (out_o),
      .out_zr     (out_zr),
      .out_ng     (out_ng),
      .out_cy     (out_cy),
      .out_ov     (out_ov),
      .acc_q      (acc_q)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [W-1:0] o, input logic zr,
                                        input logic ng, input logic cy, input logic ov);
      return {o, zr, ng, cy, ov};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [5:0] ctl, input logic acc_sel,
                          input logic [EW-1:0] exp);
      int n;
      n = 0;
      in_x       = x;
      in_y       = y;
      in_ctl     = ctl;
      in_acc_sel = acc_sel;
      in_valid   = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         #1;
         n++;
      end
      if (!in_ready) begin
         check_eq("in_accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         exp_q.push_back(exp);
         @(posedge clk);
         #1;
      end
      in_valid   = 1'b0;
      in_acc_sel = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((out_valid || exp_q.size() != 0) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   // scoreboard: a handshake seen at negedge completes on the next posedge
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("out_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            check_eq("out_result", 32'({out_o, out_zr, out_ng, out_cy, out_ov}),
                     32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_x       = '0;
      in_y       = '0;
      in_ctl     = '0;
      in_acc_sel = 1'b0;
      acc_clr    = 1'b0;
      out_ready  = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_o", 32'(out_o), 32'd0);
      check_eq("rst_flags", 32'({out_zr, out_ng, out_cy, out_ov}), 32'd0);
      check_eq("rst_acc", 32'(acc_q), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("idle_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // x+y with latency check
      send_op(16'd12, 16'd13, 6'b000010, 1'b0, mk(16'd25, 0, 0, 0, 0));
      check_eq("lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check_eq("lat_two", 32'(out_valid), 32'd1);
      wait_idle();

      // x-y, signed overflow, constant zero
      send_op(16'd12, 16'd13, 6'b010011, 1'b0, mk(16'hFFFF, 0, 1, 1, 0));
      send_op(16'h7FFF, 16'd1, 6'b000010, 1'b0, mk(16'h8000, 0, 1, 0, 1));
      send_op(16'h7FFF, 16'd1, 6'b101010, 1'b0, mk(16'h0000, 1, 0, 0, 0));
      wait_idle();

      // backpressure: two ops fill the pipe, the third waits
      out_ready = 1'b0;
      send_op(16'd1, 16'd2, 6'b000010, 1'b0, mk(16'd3, 0, 0, 0, 0));
      send_op(16'hFFFF, 16'd1, 6'b000010, 1'b0, mk(16'h0000, 1, 0, 1, 0));
      in_x     = 16'hF0F0;
      in_y     = 16'h0FF0;
      in_ctl   = 6'b000000;
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #2;
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_out_valid", 32'(out_valid), 32'd1);
         check_eq("stall_hold_o", 32'(out_o), 32'd3);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send_op(16'hF0F0, 16'h0FF0, 6'b000000, 1'b0, mk(16'h00F0, 0, 0, 0, 0));
      send_op(16'd5, 16'd0, 6'b001100, 1'b0, mk(16'd5, 0, 0, 0, 0));
      wait_idle();
      check_eq("acc_last_result", 32'(acc_q), 32'd5);

      // accumulator chain
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      check_eq("acc_clr_empty", 32'(acc_q), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         send_op(16'h5555, 16'd1, 6'b000010, 1'b1, mk(W'(i), 0, 0, 0, 0));
         in_acc_sel = 1'b1;
         #1;
         check_eq("acc_interlock_s1", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         check_eq("acc_interlock_s2", 32'(in_ready), 32'd0);
         in_acc_sel = 1'b0;
         wait_idle();
         check_eq("acc_chain", 32'(acc_q), 32'(i));
      end

      // acc_clr ignored while an op is in flight
      send_op(16'd10, 16'd5, 6'b000010, 1'b0, mk(16'd15, 0, 0, 0, 0));
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      check_eq("acc_clr_busy", 32'(acc_q), 32'd3);
      wait_idle();
      check_eq("acc_after_busy", 32'(acc_q), 32'd15);

      // reset with two ops in flight
      out_ready = 1'b0;
      send_op(16'd100, 16'd1, 6'b000010, 1'b0, mk(16'd101, 0, 0, 0, 0));
      send_op(16'd200, 16'd1, 6'b000010, 1'b0, mk(16'd201, 0, 0, 0, 0));
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_acc", 32'(acc_q), 32'd0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_eq("post_rst_no_stale", 32'(out_valid), 32'd0);
      check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
